// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified memory.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;
    logic              err_o;
    logic              stall_o;
    logic              busy_o;

    modport master (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
               mem_rdata_i, mem_ready_i,
        output if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o, mem_req_o, mem_we_o,
               mem_addr_o, mem_wdata_o, err_o, stall_o, busy_o
    );

    modport slave (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
               mem_rdata_i, mem_ready_i,
        input  if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o, mem_req_o, mem_we_o,
               mem_addr_o, mem_wdata_o, err_o, stall_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for a single-ported unified memory: data first, fetch starvation guard.
// Optional MEM_ARB_TIMEOUT_EN adds an error-ack after TIMEOUT cycles without mem_ready_i.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

    localparam int             SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(STARVE_MAX);

    state_t            state, state_nx;
    logic [SW-1:0]     streak;
    logic              if_cand, dm_cand, grant_if, grant_dm, done, tmo_hit;
    logic [DATA_W-1:0] rd_mux;

    logic              if_ack, dm_ack, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, if_rdata, dm_rdata;

    // A requester being acked this cycle is still holding its old request: mask it.
    always_comb begin
        if_cand  = bus.if_req_i & ~if_ack;
        dm_cand  = bus.dm_req_i & ~dm_ack;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        done     = 1'b0;
        state_nx = state;
        case (state)
            IDLE: begin
                if (if_cand && (!dm_cand || streak == STREAK_MAX)) begin
                    grant_if = 1'b1;
                    state_nx = GNT_IF;
                end else if (dm_cand) begin
                    grant_dm = 1'b1;
                    state_nx = GNT_DM;
                end
            end
            GNT_IF, GNT_DM: begin
                if (bus.mem_ready_i || tmo_hit) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            streak    <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state  <= state_nx;
            if_ack <= done & (state == GNT_IF);
            dm_ack <= done & (state == GNT_DM);
            if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= bus.if_addr_i;
                mem_wdata <= '0;
                streak    <= '0;
            end else if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= bus.dm_we_i;
                mem_addr  <= bus.dm_addr_i;
                mem_wdata <= bus.dm_wdata_i;
                // Streak only grows while fetch is actually waiting behind data.
                if (!bus.if_req_i)
                    streak <= '0;
                else if (streak != STREAK_MAX)
                    streak <= streak + 1'b1;
            end else if (done) begin
                mem_req <= 1'b0;
            end
            if (done && state == GNT_IF)
                if_rdata <= rd_mux;
            if (done && state == GNT_DM && !mem_we)
                dm_rdata <= rd_mux;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;
    logic          err;

    // Fires on the TIMEOUT-th waiting cycle so the error ack lands TIMEOUT cycles after grant.
    assign tmo_hit = (state != IDLE) & ~bus.mem_ready_i & (tmo_cnt == TMO_LAST);
    assign rd_mux  = tmo_hit ? DATA_W'(32'hDEADBEEF) : bus.mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            err <= done & tmo_hit;
            if (state == IDLE)
                tmo_cnt <= '0;
            else if (!bus.mem_ready_i)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign bus.err_o = err;
`else
    assign tmo_hit   = 1'b0;
    assign rd_mux    = bus.mem_rdata_i;
    assign bus.err_o = 1'b0;
`endif

    assign bus.if_ack_o    = if_ack;
    assign bus.dm_ack_o    = dm_ack;
    assign bus.if_rdata_o  = if_rdata;
    assign bus.dm_rdata_o  = dm_rdata;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.busy_o      = (state != IDLE);
    assign bus.stall_o     = (bus.if_req_i & ~if_ack) | (bus.dm_req_i & ~dm_ack);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requesters push expected responses, a negedge monitor checks every cycle
// against a rule-level arbitration model; memory is a randomized-latency responder.
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, SMAX = 4, TMO = 16;

    typedef struct packed {
        logic        we;
        logic [31:0] rd;
    } dm_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] mem     [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] if_q [$];
    dm_exp_t     dm_q [$];

    bit mem_en = 1'b0;
    bit inject_ready = 1'b0;
    int lat_max = 0;
    int wait_left = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory responder: random wait, then a one-cycle ready with data.
    initial begin : memory
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_ready_i) begin
                bus.mem_ready_i = 1'b0;
                bus.mem_rdata_i = $urandom;
            end else if (inject_ready) begin
                bus.mem_ready_i = 1'b1;
                bus.mem_rdata_i = $urandom;
                inject_ready = 1'b0;
            end else if (mem_en && bus.mem_req_o) begin
                if (wait_left < 0) wait_left = $urandom_range(0, lat_max);
                if (wait_left == 0) begin
                    if (bus.mem_we_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
                    else bus.mem_rdata_i = mem.exists(bus.mem_addr_o) ? mem[bus.mem_addr_o]
                                                                        : init_word(bus.mem_addr_o);
                    bus.mem_ready_i = 1'b1;
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    task automatic if_issue(input logic [31:0] a);
        int n = 0;
        if_q.push_back(ref_mem.exists(a) ? ref_mem[a] : init_word(a));
        bus.if_addr_i = a;
        bus.if_req_i  = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!bus.if_ack_o && n < 300);
        if (!bus.if_ack_o) begin
            vec_cnt++; err_cnt++;
            $display("FAIL if_ack_wait: no ack for addr %h within 300 cycles", a);
        end else if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
        end
        bus.if_req_i = 1'b0;
    endtask

    task automatic dm_issue(input logic we, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        dm_exp_t d;
        d.we = we;
        if (we) begin
            ref_mem[a] = wd;
            d.rd = '0;
        end else begin
            d.rd = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
        end
        dm_q.push_back(d);
        bus.dm_we_i    = we;
        bus.dm_addr_i  = a;
        bus.dm_wdata_i = wd;
        bus.dm_req_i   = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!bus.dm_ack_o && n < 300);
        if (!bus.dm_ack_o) begin
            vec_cnt++; err_cnt++;
            $display("FAIL dm_ack_wait: no ack for addr %h within 300 cycles", a);
        end else if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
        end
        bus.dm_req_i = 1'b0;
    endtask

    // Monitor with the arbitration rules kept as a few flags and counters.
    bit          m_busy = 0, m_own_dm = 0;
    int          m_streak = 0, m_wait = 0;
    bit          e_ack_if = 0, e_ack_dm = 0, e_err = 0, e_grant = 0, e_we = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_if_rd = '0, e_dm_rd = '0;

    initial begin : monitor
        bit          n_ack_if, n_ack_dm, n_err, n_grant, ci, cd, win_if, tmo;
        logic [31:0] tmp;
        dm_exp_t     dx;
        forever begin
            @(negedge clk);
            chk("if_ack", 32'(bus.if_ack_o), 32'(e_ack_if));
            chk("dm_ack", 32'(bus.dm_ack_o), 32'(e_ack_dm));
            if (bus.if_ack_o && if_q.size() > 0) begin
                tmp = if_q.pop_front();
                e_if_rd = e_err ? 32'hDEADBEEF : tmp;
            end
            if (bus.dm_ack_o && dm_q.size() > 0) begin
                dx = dm_q.pop_front();
                if (!dx.we) e_dm_rd = e_err ? 32'hDEADBEEF : dx.rd;
            end
            chk("if_rdata", bus.if_rdata_o, e_if_rd);
            chk("dm_rdata", bus.dm_rdata_o, e_dm_rd);
            chk("err", 32'(bus.err_o), 32'(e_err));
            chk("mem_req", 32'(bus.mem_req_o), 32'(m_busy));
            chk("busy", 32'(bus.busy_o), 32'(m_busy));
            chk("stall", 32'(bus.stall_o),
                32'((bus.if_req_i & ~e_ack_if) | (bus.dm_req_i & ~e_ack_dm)));
            if (e_grant) begin
                chk("mem_addr", bus.mem_addr_o, e_addr);
                chk("mem_we", 32'(bus.mem_we_o), 32'(e_we));
                chk("mem_wdata", bus.mem_wdata_o, e_wdata);
            end

            n_ack_if = 0; n_ack_dm = 0; n_err = 0; n_grant = 0;
            if (!rst_n) begin
                m_busy = 0; m_streak = 0; e_if_rd = '0; e_dm_rd = '0;
            end else if (m_busy) begin
                tmo = 0;
`ifdef MEM_ARB_TIMEOUT_EN
                tmo = !bus.mem_ready_i && (m_wait == TMO - 1);
`endif
                if (bus.mem_ready_i || tmo) begin
                    if (m_own_dm) n_ack_dm = 1; else n_ack_if = 1;
                    n_err  = tmo;
                    m_busy = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                ci = bus.if_req_i && !e_ack_if;
                cd = bus.dm_req_i && !e_ack_dm;
                if (ci || cd) begin
                    win_if   = ci && (!cd || m_streak == SMAX);
                    n_grant  = 1;
                    m_busy   = 1;
                    m_wait   = 0;
                    m_own_dm = !win_if;
                    if (win_if) begin
                        e_we = 0; e_addr = bus.if_addr_i; e_wdata = '0; m_streak = 0;
                    end else begin
                        e_we = bus.dm_we_i; e_addr = bus.dm_addr_i; e_wdata = bus.dm_wdata_i;
                        m_streak = !bus.if_req_i ? 0 : (m_streak < SMAX ? m_streak + 1 : SMAX);
                    end
                end
            end
            e_ack_if = n_ack_if; e_ack_dm = n_ack_dm; e_err = n_err; e_grant = n_grant;
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        bus.if_req_i = 0; bus.if_addr_i = '0;
        bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
        mem[32'h40] = 32'h8C020004;
        ref_mem[32'h40] = 32'h8C020004;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;

        // Reset while a data load is in flight; a late ready must not produce an ack.
        bus.dm_we_i = 0; bus.dm_addr_i = 32'h2100; bus.dm_req_i = 1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.mem_req_o && n < 10);
        chk("rst_setup_mem_req", 32'(bus.mem_req_o), 32'd1);
        rst_n = 1'b0;
        bus.dm_req_i = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'd0);
        chk("rst_dm_rdata", bus.dm_rdata_o, 32'd0);
        inject_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single minimum-latency fetch.
        mem_en = 1'b1; lat_max = 0; wait_left = -1;
        if_issue(32'h40);
        repeat (2) begin @(posedge clk); #1; end

        // Simultaneous requests: data first, fetch back-to-back in the data ack cycle.
        fork
            if_issue(32'h1000);
            dm_issue(1'b0, 32'h100, '0);
        join
        repeat (2) begin @(posedge clk); #1; end

        // Fetch held while data keeps re-requesting.
        fork
            if_issue(32'h1004);
            for (int i = 0; i < 6; i++) dm_issue(1'b0, 32'h2000 + 32'(4 * i), '0);
        join
        repeat (2) begin @(posedge clk); #1; end

        // Store leaves dm_rdata untouched; read it back afterwards.
        dm_issue(1'b1, 32'h20, 32'h12345678);
        dm_issue(1'b0, 32'h20, '0);

        // Randomized traffic with random memory latency.
        lat_max = 3;
        fork
            for (int i = 0; i < 120; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if_issue(32'h1000 + 32'($urandom_range(0, 1023) * 4));
            end
            for (int j = 0; j < 120; j++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                dm_issue(1'($urandom_range(0, 1)), 32'h2000 + 32'($urandom_range(0, 15) * 4),
                         $urandom);
            end
        join

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: expect an error ack with the poison word.
        repeat (2) begin @(posedge clk); #1; end
        mem_en = 1'b0;
        if_issue(32'h1008);
        repeat (2) begin @(posedge clk); #1; end
        mem_en = 1'b1; wait_left = -1;
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("dm_q_drained", 32'(dm_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
